// File: rtl/fp16_pkg.sv
// Shared fp16 definitions: field widths, special encodings and the accumulator state set.
package fp16_pkg;

    localparam int unsigned FP16_W        = 16;
    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
    localparam logic [15:0] FP16_QNAN     = 16'h7E00;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

endpackage

// File: rtl/fp16_add.sv
// Combinational IEEE binary16 adder, round-to-nearest-even, with subnormals, infinities and NaN.
module fp16_add
    import fp16_pkg::*;
(
    input  logic [FP16_W-1:0] a,
    input  logic [FP16_W-1:0] b,
    output logic [FP16_W-1:0] result
);

    logic        a_nan, b_nan, a_inf, b_inf;
    logic [15:0] x, y;
    logic [4:0]  ex, ey, d;
    logic [13:0] mx, my, ysh, mask;
    logic [14:0] s;
    logic [5:0]  e;
    logic [14:0] packed_mag;
    logic        rnd, rs;

    always_comb begin
        a_nan = (&a[14:10]) && (|a[9:0]);
        b_nan = (&b[14:10]) && (|b[9:0]);
        a_inf = (&a[14:10]) && !(|a[9:0]);
        b_inf = (&b[14:10]) && !(|b[9:0]);

        // x always carries the larger magnitude so the difference never goes negative
        if (a[14:0] >= b[14:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end

        ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
        ey = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
        mx = {(x[14:10] != 5'd0), x[9:0], 3'b000};
        my = {(y[14:10] != 5'd0), y[9:0], 3'b000};
        d  = ex - ey;

        // Low three bits are guard, round and sticky
        mask = 14'd0;
        if (d >= 5'd14) begin
            ysh = {13'd0, |my};
        end else begin
            mask   = (14'd1 << d) - 14'd1;
            ysh    = my >> d;
            ysh[0] = ysh[0] | (|(my & mask));
        end

        if (x[15] == y[15]) s = {1'b0, mx} + {1'b0, ysh};
        else                s = {1'b0, mx} - {1'b0, ysh};

        e = {1'b0, ex};
        if (s[14]) begin
            s = {1'b0, s[14:2], s[1] | s[0]};
            e = e + 6'd1;
        end
        for (int i = 0; i < 13; i++) begin
            if (!s[13] && (e > 6'd1)) begin
                s = s << 1;
                e = e - 6'd1;
            end
        end

        rnd = s[2] & (s[1] | s[0] | s[3]);
        // Rounding carry ripples from fraction into exponent, covering subnormal->normal and overflow
        packed_mag = {(s[13] ? e[4:0] : 5'd0), s[12:3]} + {14'd0, rnd};

        rs = (s == 15'd0) ? (x[15] & y[15]) : x[15];

        if (a_nan || b_nan)      result = FP16_QNAN;
        else if (a_inf && b_inf) result = (a[15] != b[15]) ? FP16_QNAN : a;
        else if (a_inf)          result = a;
        else if (b_inf)          result = b;
        else if (e >= 6'd31)     result = {rs, 5'h1f, 10'h000};
        else                     result = {rs, packed_mag};
    end

endmodule

// File: rtl/fp16_accum_ctrl.sv
// Streams len fp16 elements through one fp16_add into an accumulator and hands out the sum.
module fp16_accum_ctrl
    import fp16_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    input  logic [FP16_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [FP16_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    state_e             state_q;
    logic [FP16_W-1:0]  acc_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [LEN_W-1:0]   len_q;
    logic [FP16_W-1:0]  sum;

    fp16_add u_add (
        .a      (acc_q),
        .b      (in_data),
        .result (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= FP16_POS_ZERO;
            cnt_q   <= '0;
            len_q   <= '0;
        end else if (abort) begin
            state_q <= IDLE;
            acc_q   <= FP16_POS_ZERO;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q   <= len;
                        acc_q   <= FP16_POS_ZERO;
                        cnt_q   <= '0;
                        state_q <= (len != '0) ? ACC : DONE;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc_q <= sum;
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (cnt_q == len_q - LEN_W'(1)) state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake strobes are masked by abort in the same cycle so nothing is accepted or delivered
    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == ACC) && !abort;
    assign out_valid = (state_q == DONE) && !abort;
    assign out_data  = acc_q;

endmodule

// File: tb/tb_fp16_accum_ctrl.sv
// Scenario bench for fp16_accum_ctrl; expected sums are queued at stimulus time and checked on delivery.
module tb_fp16_accum_ctrl;
    import fp16_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        abort = 1'b0;
    logic        busy;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] sb_exp;

    fp16_accum_ctrl #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: out_data=%h delivered but no result expected", out_data);
            end else begin
                sb_exp = exp_q.pop_front();
                if (out_data !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_result: out_data=%h expected %h", out_data, sb_exp);
                end
            end
        end
    end

    task automatic start_run(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: out_valid=%b required 1", out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks += 4;
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(16'h4200);
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        start_run(8'd2);
        @(negedge clk);
        checks += 2;
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL b2b_in_ready_c1: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_out_valid_c1: got %b want 0", out_valid); end
        @(posedge clk);
        #1 in_data = 16'h4000;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_out_valid_c2: got %b want 0", out_valid); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid_c3: got %b want 1", out_valid); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: busy=%b want 0", busy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_gaps();
        exp_q.push_back(16'h4400);
        start_run(8'd4);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h3C00;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL gaps_in_ready_el%0d: got %b want 1", k, in_ready); end
            @(posedge clk);
            #1 in_valid = 1'b0;
            if (k < 3) begin
                for (int g = 0; g < 2; g++) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL gaps_idle_cycle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
                    end
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_out();
    endtask

    task automatic test_len_zero();
        exp_q.push_back(16'h0000);
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        start    = 1'b1;
        len      = 8'd0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL len0_in_ready_idle: got %b want 0", in_ready); end
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL len0_out_valid: got %b want 1", out_valid); end
        if (in_ready !== 1'b0)  begin errors++; $display("FAIL len0_in_ready_done: got %b want 0", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL len0_idle_after: busy=%b want 0", busy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        exp_q.push_back(16'h3800);
        start_run(8'd1);
        feed(16'h3800);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h3800) begin
                errors++;
                $display("FAIL bp_hold_c%0d: out_valid=%b out_data=%h want 1/3800", i, out_valid, out_data);
            end
            @(posedge clk);
            #1 start = (i == 1);
            len = 8'd3;
        end
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_start_ignored: busy=%b out_valid=%b want 0/0", busy, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_abort();
        start_run(8'd4);
        feed(16'h3C00);
        feed(16'h3C00);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_strobes: in_ready=%b out_valid=%b want 0/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1 abort = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0)         begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (out_data !== 16'h0000) begin errors++; $display("FAIL abort_acc: got %h want 0000", out_data); end
        @(posedge clk);
        #1;
        exp_q.push_back(16'h4000);
        start_run(8'd1);
        feed(16'h4000);
        wait_out();
    endtask

    task automatic test_async_reset();
        start_run(8'd4);
        feed(16'h3C00);
        feed(16'h4000);
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        #3 rst_n = 1'b0;
        #1;
        checks += 4;
        if (busy !== 1'b0)         begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
        if (in_ready !== 1'b0)     begin errors++; $display("FAIL arst_in_ready: got %b want 0", in_ready); end
        if (out_valid !== 1'b0)    begin errors++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
        if (out_data !== 16'h0000) begin errors++; $display("FAIL arst_out_data: got %h want 0000", out_data); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL arst_no_resume_c%0d: out_valid=%b busy=%b want 0/0", i, out_valid, busy);
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_arith();
        // 1+2+3+4+5 = 15
        exp_q.push_back(16'h4B80);
        start_run(8'd5);
        feed(16'h3C00);
        feed(16'h4000);
        feed(16'h4200);
        feed(16'h4400);
        feed(16'h4500);
        wait_out();
        // 3 + (-2) = 1, exercises the subtract path
        exp_q.push_back(16'h3C00);
        start_run(8'd2);
        feed(16'h4200);
        feed(16'hC000);
        wait_out();
        // 2048 + 1 rounds back to 2048, then + 3 ties to even at 2052
        exp_q.push_back(16'h6802);
        start_run(8'd3);
        feed(16'h6800);
        feed(16'h3C00);
        feed(16'h4200);
        wait_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_len_zero();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_arith();
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d results outstanding, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
